// File: rtl/regfile_scoreboard_pkg.sv
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared types and constants for the register-file scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [0:0] {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_t;
endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
// ============================================================================
//  Module      : regfile_scoreboard_if
//  Description : Issue / writeback / flush bundle between decode and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_scoreboard_if
    import rf_pkg::*;
#(
    parameter int TOT_W = 4
);
    logic                issue_valid;
    reg_idx_t            issue_rs1;
    reg_idx_t            issue_rs2;
    logic                issue_use_rs1;
    logic                issue_use_rs2;
    reg_idx_t            issue_rd;
    logic                issue_we;
    logic                issue_ready;
    logic                wb_valid;
    reg_idx_t            wb_rd;
    logic                flush_req;
    logic                flush_done;
    logic [NUM_REGS-1:0] busy_mask;
    logic [TOT_W-1:0]    outstanding;
    logic                err_underflow;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_we, wb_valid, wb_rd, flush_req,
        input  issue_ready, flush_done, busy_mask, outstanding, err_underflow
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_we, wb_valid, wb_rd, flush_req,
        output issue_ready, flush_done, busy_mask, outstanding, err_underflow
    );
endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard_counter.sv
// ============================================================================
//  Module      : sb_counter
//  Description : Saturating up/down pending-write counter with underflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_counter #(
    parameter int CNT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_dec,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_underflow
);
    localparam logic [CNT_W-1:0] C_MAX  = '1;
    localparam logic [CNT_W-1:0] C_ZERO = '0;
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // A paired inc/dec nets to zero, so only an unpaired dec can underflow.
    assign o_underflow = i_dec && !i_inc && (r_count == C_ZERO);
    assign o_count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= C_ZERO;
        end else if (i_inc && !i_dec) begin
            if (r_count != C_MAX) r_count <= r_count + C_ONE;
        end else if (i_dec && !i_inc) begin
            if (r_count != C_ZERO) r_count <= r_count - C_ONE;
        end
    end
endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register pending-write tracker gating issue on RAW hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int TOT_W = 4
) (
    input wire logic             clk,
    input wire logic             rst,
    regfile_scoreboard_if.slave  sb
);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [TOT_W-1:0] C_TOT_MAX  = '1;
    localparam logic [TOT_W-1:0] C_TOT_ZERO = '0;
    localparam logic [TOT_W-1:0] C_TOT_ONE  = TOT_W'(1);

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc, w_dec, w_uf, w_busy;
    logic                w_fire, w_ready, w_done;
    logic                w_hit1, w_hit2, w_pend1, w_pend2, w_rd_sat, w_tot_sat;
    logic                w_inc_any, w_dec_any;
    logic [TOT_W-1:0]    r_outstanding, w_out_nxt;
    sb_state_t           r_state, w_state_nxt;
    logic                r_err;

    assign w_cnt[0] = C_CNT_ZERO;
    assign w_inc[0] = 1'b0;
    assign w_dec[0] = 1'b0;
    assign w_uf[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            assign w_inc[gi] = w_fire && sb.issue_we && (sb.issue_rd == reg_idx_t'(gi));
            assign w_dec[gi] = sb.wb_valid && (sb.wb_rd == reg_idx_t'(gi));
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk         (clk),
                .rst         (rst),
                .i_inc       (w_inc[gi]),
                .i_dec       (w_dec[gi]),
                .o_count     (w_cnt[gi]),
                .o_underflow (w_uf[gi])
            );
        end
    endgenerate

    // Same-cycle writeback forwards through the regfile, so it discounts one pending write.
    always_comb begin
        w_hit1    = sb.wb_valid && (sb.wb_rd == sb.issue_rs1) && (sb.issue_rs1 != '0);
        w_hit2    = sb.wb_valid && (sb.wb_rd == sb.issue_rs2) && (sb.issue_rs2 != '0);
        w_pend1   = (w_cnt[sb.issue_rs1] - (w_hit1 ? C_CNT_ONE : C_CNT_ZERO)) != C_CNT_ZERO;
        w_pend2   = (w_cnt[sb.issue_rs2] - (w_hit2 ? C_CNT_ONE : C_CNT_ZERO)) != C_CNT_ZERO;
        w_rd_sat  = sb.issue_we && (sb.issue_rd != '0) && (w_cnt[sb.issue_rd] == C_CNT_MAX)
                    && !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
        w_tot_sat = sb.issue_we && (sb.issue_rd != '0) && (r_outstanding == C_TOT_MAX)
                    && !sb.wb_valid;
        w_ready   = (r_state == SB_RUN) && !sb.flush_req
                    && !(sb.issue_use_rs1 && w_pend1) && !(sb.issue_use_rs2 && w_pend2)
                    && !w_rd_sat && !w_tot_sat;
        w_fire    = sb.issue_valid && w_ready;
    end

    always_comb begin
        w_inc_any = |w_inc;
        w_dec_any = |(w_dec & ~w_uf);
        w_out_nxt = r_outstanding;
        if (w_inc_any && !w_dec_any && (r_outstanding != C_TOT_MAX)) begin
            w_out_nxt = r_outstanding + C_TOT_ONE;
        end else if (!w_inc_any && w_dec_any && (r_outstanding != C_TOT_ZERO)) begin
            w_out_nxt = r_outstanding - C_TOT_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            SB_RUN: begin
                if (sb.flush_req) w_state_nxt = SB_DRAIN;
            end
            SB_DRAIN: begin
                if (w_out_nxt == C_TOT_ZERO) begin
                    w_done      = 1'b1;
                    w_state_nxt = sb.flush_req ? SB_DRAIN : SB_RUN;
                end
            end
            default: w_state_nxt = SB_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= SB_RUN;
            r_outstanding <= C_TOT_ZERO;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;
            if (|w_uf) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 1; i < NUM_REGS; i++) w_busy[i] = (w_cnt[i] != C_CNT_ZERO);
    end

    assign sb.issue_ready   = w_ready;
    assign sb.flush_done    = w_done;
    assign sb.busy_mask     = w_busy;
    assign sb.outstanding   = r_outstanding;
    assign sb.err_underflow = r_err;
endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed and random stimulus against a behavioural scoreboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;
    import rf_pkg::*;

    localparam int CNT_W = 2;
    localparam int TOT_W = 4;
    localparam int CMAX  = 3;
    localparam int TMAX  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_scoreboard_if #(.TOT_W(TOT_W)) sb ();

    regfile_scoreboard #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int m_cnt [32];
    int m_out;
    bit m_drain;
    bit m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pend(input int s);
        if (s == 0) return 0;
        return m_cnt[s] - ((sb.wb_valid && int'(sb.wb_rd) == s) ? 1 : 0);
    endfunction

    function automatic bit m_ready();
        int rd = int'(sb.issue_rd);
        if (m_drain || sb.flush_req) return 1'b0;
        if (sb.issue_use_rs1 && pend(int'(sb.issue_rs1)) != 0) return 1'b0;
        if (sb.issue_use_rs2 && pend(int'(sb.issue_rs2)) != 0) return 1'b0;
        if (sb.issue_we && rd != 0 && m_cnt[rd] == CMAX && !(sb.wb_valid && int'(sb.wb_rd) == rd))
            return 1'b0;
        if (sb.issue_we && rd != 0 && m_out == TMAX && !sb.wb_valid) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_next_out(input bit fire);
        int inc = (fire && sb.issue_we && sb.issue_rd != 0) ? 1 : 0;
        int dec = 0;
        int n;
        if (sb.wb_valid && sb.wb_rd != 0 &&
            (m_cnt[sb.wb_rd] > 0 || (inc == 1 && sb.issue_rd == sb.wb_rd))) dec = 1;
        n = m_out + inc - dec;
        if (n > TMAX) n = TMAX;
        if (n < 0) n = 0;
        return n;
    endfunction

    // Reference model: advanced on every clock edge from the sampled inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_out   = 0;
            m_drain = 1'b0;
            m_err   = 1'b0;
        end else begin : mdl
            bit f;
            int nout;
            int wr;
            int rd;
            f    = sb.issue_valid && m_ready();
            nout = m_next_out(f);
            wr   = int'(sb.wb_rd);
            rd   = int'(sb.issue_rd);
            if (!m_drain) m_drain = sb.flush_req;
            else if (nout == 0) m_drain = sb.flush_req;
            if (sb.wb_valid && wr != 0) begin
                if (m_cnt[wr] == 0 && !(f && sb.issue_we && rd == wr)) m_err = 1'b1;
                else m_cnt[wr]--;
            end
            if (f && sb.issue_we && rd != 0) m_cnt[rd]++;
            m_out = nout;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin : cmp
            logic [31:0] eb;
            eb = '0;
            for (int i = 1; i < 32; i++) eb[i] = (m_cnt[i] != 0);
            chk("issue_ready",   sb.issue_ready,   m_ready());
            chk("flush_done",    sb.flush_done,    m_drain && m_next_out(1'b0) == 0);
            chk("busy_mask",     sb.busy_mask,     eb);
            chk("outstanding",   sb.outstanding,   m_out);
            chk("err_underflow", sb.err_underflow, m_err);
        end
    end

    task automatic idle();
        sb.issue_valid   = 1'b0;
        sb.issue_rs1     = '0;
        sb.issue_rs2     = '0;
        sb.issue_use_rs1 = 1'b0;
        sb.issue_use_rs2 = 1'b0;
        sb.issue_rd      = '0;
        sb.issue_we      = 1'b0;
        sb.wb_valid      = 1'b0;
        sb.wb_rd         = '0;
        sb.flush_req     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input int rd);
        idle();
        sb.issue_valid = 1'b1;
        sb.issue_we    = 1'b1;
        sb.issue_rd    = reg_idx_t'(rd);
        step();
    endtask

    task automatic wb(input int rd);
        idle();
        sb.wb_valid = 1'b1;
        sb.wb_rd    = reg_idx_t'(rd);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  sb.busy_mask, 32'h0);
        chk("rst_out",   sb.outstanding, 0);
        chk("rst_err",   sb.err_underflow, 0);
        chk("rst_done",  sb.flush_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // RAW hazard with writeback forwarding
        idle();
        sb.issue_valid = 1'b1; sb.issue_we = 1'b1; sb.issue_rd = 5'd5;
        @(negedge clk); chk("raw_first_ready", sb.issue_ready, 1);
        step();
        sb.issue_we = 1'b0; sb.issue_use_rs1 = 1'b1; sb.issue_rs1 = 5'd5;
        @(negedge clk); chk("raw_stall", sb.issue_ready, 0); chk("raw_busy5", sb.busy_mask[5], 1);
        step(); step();
        sb.wb_valid = 1'b1; sb.wb_rd = 5'd5;
        @(negedge clk); chk("raw_fwd_ready", sb.issue_ready, 1);
        step(); idle();
        @(negedge clk); chk("raw_clear", sb.busy_mask[5], 0);

        // per-register saturation
        issue_wr(7); issue_wr(7); issue_wr(7);
        sb.issue_valid = 1'b1; sb.issue_we = 1'b1; sb.issue_rd = 5'd7;
        @(negedge clk);
        chk("sat_busy7", sb.busy_mask[7], 1);
        chk("sat_out", sb.outstanding, 3);
        chk("sat_stall", sb.issue_ready, 0);
        sb.wb_valid = 1'b1; sb.wb_rd = 5'd7;
        @(negedge clk); chk("sat_wb_ready", sb.issue_ready, 1);
        step(); idle();
        @(negedge clk); chk("sat_hold", sb.outstanding, 3);
        wb(7); wb(7); wb(7); idle();
        @(negedge clk); chk("sat_drained", sb.outstanding, 0);

        // x0 is never tracked
        sb.issue_valid = 1'b1; sb.issue_we = 1'b1; sb.issue_rd = 5'd0;
        @(negedge clk); chk("x0_wr_ready", sb.issue_ready, 1);
        step();
        sb.issue_we = 1'b0; sb.issue_use_rs1 = 1'b1; sb.issue_rs1 = 5'd0;
        @(negedge clk); chk("x0_rd_ready", sb.issue_ready, 1);
        step(); idle();
        @(negedge clk); chk("x0_out", sb.outstanding, 0); chk("x0_busy", sb.busy_mask, 32'h0);

        // flush and drain
        issue_wr(3); issue_wr(9); idle();
        sb.flush_req = 1'b1; sb.issue_valid = 1'b1;
        @(negedge clk); chk("flush_stall", sb.issue_ready, 0); chk("flush_out2", sb.outstanding, 2);
        step(); idle();
        sb.wb_valid = 1'b1; sb.wb_rd = 5'd3;
        @(negedge clk); chk("flush_not_done", sb.flush_done, 0);
        step();
        sb.wb_rd = 5'd9;
        @(negedge clk); chk("flush_done_pulse", sb.flush_done, 1);
        step(); idle();
        @(negedge clk);
        chk("flush_done_low", sb.flush_done, 0);
        chk("flush_run_ready", sb.issue_ready, 1);
        chk("flush_out0", sb.outstanding, 0);

        // underflow
        wb(12); idle();
        @(negedge clk);
        chk("uf_err", sb.err_underflow, 1);
        chk("uf_out", sb.outstanding, 0);
        chk("uf_busy12", sb.busy_mask[12], 0);

        // asynchronous reset in the middle of a drain
        issue_wr(1); issue_wr(2); issue_wr(3); idle();
        sb.flush_req = 1'b1;
        step(); idle();
        @(negedge clk); chk("ar_out3", sb.outstanding, 3); chk("ar_drain", sb.issue_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_out", sb.outstanding, 0);
        chk("ar_busy", sb.busy_mask, 32'h0);
        chk("ar_err", sb.err_underflow, 0);
        chk("ar_done", sb.flush_done, 0);
        chk("ar_run", sb.issue_ready, 1);
        rst = 1'b0;
        step();

        // random traffic on a small register window to provoke hazards and limits
        for (int c = 0; c < 3000; c++) begin : rnd
            int r;
            sb.issue_valid   = ($urandom_range(0, 9) < 7);
            sb.issue_rs1     = reg_idx_t'($urandom_range(0, 7));
            sb.issue_rs2     = reg_idx_t'($urandom_range(0, 7));
            sb.issue_use_rs1 = $urandom_range(0, 1) == 1;
            sb.issue_use_rs2 = $urandom_range(0, 1) == 1;
            sb.issue_rd      = reg_idx_t'($urandom_range(0, 7));
            sb.issue_we      = ($urandom_range(0, 9) < 6);
            r                = $urandom_range(0, 7);
            sb.wb_rd         = reg_idx_t'(r);
            sb.wb_valid      = (m_cnt[r] > 0) ? ($urandom_range(0, 2) != 0)
                                              : ($urandom_range(0, 99) == 0);
            sb.flush_req     = ($urandom_range(0, 39) == 0);
            step();
        end

        idle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
